// File: rtl/imem_load_ctrl_pkg.sv
// Shared types and constants for the instruction memory loader.
package imem_load_ctrl_pkg;

    // Load FSM state encodings (2 bits).
    typedef enum logic [1:0] {
        LS_IDLE = 2'd0,
        LS_LOAD = 2'd1,
        LS_RUN  = 2'd2,
        LS_ERR  = 2'd3
    } load_state_t;

    // Default memory size, shared with fetch.
    localparam int MEM_SIZE_DEFAULT = 1024;

    // Bytes presented to fetch per read.
    localparam int READ_BYTES = 10;

endpackage

// File: rtl/imem_load_ctrl_bram.sv
// Instruction byte memory: one synchronous byte write port and a
// combinational 10-byte read port.
//   - A read address at or beyond the end of memory returns 8'h00.
//   - A write lands at the clock edge, so a same-cycle read sees the old byte.
module imem_load_ctrl_bram
    import imem_load_ctrl_pkg::*;
#(
    parameter int MEM_SIZE = MEM_SIZE_DEFAULT,
    parameter int AW       = $clog2(MEM_SIZE)
) (
    input  logic                    clk_i,
    input  logic                    we,
    input  logic [AW-1:0]           waddr,
    input  logic [7:0]              wdata,
    input  logic [63:0]             raddr,
    output logic [READ_BYTES*8-1:0] rdata
);

    logic [7:0] mem [MEM_SIZE];

    // Byte write port; memory contents are deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Combinational read of 10 consecutive bytes.
    // The address is widened to 65 bits so that an address near 2^64
    // never wraps around into the valid range.
    always_comb begin
        logic [64:0] addr;
        addr  = '0;
        rdata = '0;
        for (int i = 0; i < READ_BYTES; i++) begin
            addr = {1'b0, raddr} + 65'(i);
            if (addr < 65'(MEM_SIZE)) begin
                rdata[i*8 +: 8] = mem[addr[AW-1:0]];
            end
        end
    end

endmodule

// File: rtl/imem_load_ctrl.sv
// Instruction memory load controller.
//   - LOAD: accepts a byte stream from the host loader.
//   - RUN:  hands the memory to fetch and releases the pipeline.
//
// Load port handshake: a byte transfers on a rising edge where
// load_valid_i & load_ready_o. load_ready_o is high only in LOAD.
// load_start_i in the same cycle wins, and that byte is dropped.
module imem_load_ctrl
    import imem_load_ctrl_pkg::*;
#(
    parameter int MEM_SIZE = MEM_SIZE_DEFAULT,
    parameter int AW       = $clog2(MEM_SIZE)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    load_start_i,
    input  logic                    load_valid_i,
    input  logic [7:0]              load_data_i,
    input  logic                    load_last_i,
    output logic                    load_ready_o,
    output logic [AW:0]             load_count_o,
    output logic                    load_done_o,
    output logic                    load_err_o,
    output logic                    cpu_stall_o,
    input  logic [63:0]             f_PC_i,
    output logic [READ_BYTES*8-1:0] rdata_o,
    output logic                    imem_error_o,
    output load_state_t             load_state_o
);

    load_state_t   state;
    load_state_t   state_next;
    logic [AW-1:0] wr_ptr;
    logic          handshake;
    logic          wr_en;
    logic          at_end;

    assign handshake = load_valid_i & load_ready_o;
    assign wr_en     = handshake & ~load_start_i;
    assign at_end    = (wr_ptr == AW'(MEM_SIZE - 1));

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= LS_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and outputs decoded from the current state.
    always_comb begin
        state_next   = state;
        load_ready_o = 1'b0;
        load_done_o  = 1'b0;
        load_err_o   = 1'b0;
        cpu_stall_o  = 1'b1;
        case (state)
            LS_IDLE: begin
            end
            LS_LOAD: begin
                load_ready_o = 1'b1;
                if (handshake && load_last_i) begin
                    state_next = LS_RUN;
                end else if (handshake && at_end) begin
                    state_next = LS_ERR;
                end
            end
            LS_RUN: begin
                load_done_o = 1'b1;
                cpu_stall_o = 1'b0;
            end
            LS_ERR: begin
                load_err_o = 1'b1;
            end
            default: state_next = LS_IDLE;
        endcase
        if (load_start_i) begin
            state_next = LS_LOAD;
        end
    end

    // Write pointer and byte counter. A start clears both; an accepted
    // byte advances both.
    always_ff @(posedge clk_i) begin
        if (rst_i || load_start_i) begin
            wr_ptr       <= '0;
            load_count_o <= '0;
        end else if (wr_en) begin
            wr_ptr       <= wr_ptr + AW'(1);
            load_count_o <= load_count_o + (AW+1)'(1);
        end
    end

    assign imem_error_o = (f_PC_i >= 64'(MEM_SIZE));
    assign load_state_o = state;

    imem_load_ctrl_bram #(
        .MEM_SIZE (MEM_SIZE),
        .AW       (AW)
    ) u_bram (
        .clk_i (clk_i),
        .we    (wr_en),
        .waddr (wr_ptr),
        .wdata (load_data_i),
        .raddr (f_PC_i),
        .rdata (rdata_o)
    );

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Directed bench for imem_load_ctrl with hand-computed expectations.
module tb_imem_load_ctrl;
    import imem_load_ctrl_pkg::*;

    localparam int MS = 1024;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          load_start = 1'b0;
    logic          load_valid = 1'b0;
    logic [7:0]    load_data = 8'h00;
    logic          load_last = 1'b0;
    logic          load_ready;
    logic [AW:0]   load_count;
    logic          load_done;
    logic          load_err;
    logic          cpu_stall;
    logic [63:0]   f_pc = 64'd0;
    logic [79:0]   rdata;
    logic          imem_error;
    load_state_t   load_state;

    int total = 0;
    int bad   = 0;

    logic [7:0] prog [10];
    logic [7:0] fill_byte;
    logic [31:0] exp_word;

    imem_load_ctrl #(.MEM_SIZE(MS), .AW(AW)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .load_start_i (load_start),
        .load_valid_i (load_valid),
        .load_data_i  (load_data),
        .load_last_i  (load_last),
        .load_ready_o (load_ready),
        .load_count_o (load_count),
        .load_done_o  (load_done),
        .load_err_o   (load_err),
        .cpu_stall_o  (cpu_stall),
        .f_PC_i       (f_pc),
        .rdata_o      (rdata),
        .imem_error_o (imem_error),
        .load_state_o (load_state)
    );

    // Clock generation.
    always #5 clk = ~clk;

    // Single comparison point.
    task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse load_start for one cycle.
    task automatic start_load();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    // Present one byte for one cycle.
    task automatic send_byte(input logic [7:0] d, input logic last);
        load_valid = 1'b1;
        load_data  = d;
        load_last  = last;
        tick();
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    function automatic logic [7:0] ovf_byte(input int i);
        logic [7:0] v;
        v = i[7:0];
        return v ^ 8'h5A;
    endfunction

    initial begin
        prog[0] = 8'h30; prog[1] = 8'hF2; prog[2] = 8'h0A;
        for (int i = 3; i < 10; i++) prog[i] = 8'h00;

        // Reset state
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_ready", 80'(load_ready), 80'd0);
        check("rst_stall", 80'(cpu_stall), 80'd1);
        check("rst_done",  80'(load_done), 80'd0);
        check("rst_err",   80'(load_err), 80'd0);
        check("rst_count", 80'(load_count), 80'd0);
        check("rst_state", 80'(load_state), 80'(LS_IDLE));

        // 10-byte program load
        start_load();
        check("load_ready", 80'(load_ready), 80'd1);
        check("load_stall", 80'(cpu_stall), 80'd1);
        for (int i = 0; i < 10; i++) send_byte(prog[i], i == 9);
        check("prog_count", 80'(load_count), 80'd10);
        check("prog_done",  80'(load_done), 80'd1);
        check("prog_stall", 80'(cpu_stall), 80'd0);
        f_pc = 64'd0;
        #1;
        check("prog_rd16", 80'(rdata[15:0]), 80'h F230);
        check("prog_rd80", rdata, 80'h0000_0000_0000_000A_F230);
        check("prog_ierr", 80'(imem_error), 80'd0);
        // Loader ignored in RUN
        send_byte(8'hFF, 1'b1);
        check("run_ignore_count", 80'(load_count), 80'd10);
        check("run_ignore_mem", 80'(rdata[15:0]), 80'h F230);

        // Valid toggled every other cycle; idle cycles carry junk data
        start_load();
        send_byte(8'hA0, 1'b0);
        load_data = 8'hEE; tick();
        send_byte(8'hA1, 1'b0);
        load_data = 8'hEE; tick();
        send_byte(8'hA2, 1'b1);
        check("tog_count", 80'(load_count), 80'd3);
        check("tog_done",  80'(load_done), 80'd1);
        check("tog_mem",   80'(rdata[31:0]), 80'h00A2_A1A0);

        // Start together with a valid byte: byte dropped
        start_load();
        load_start = 1'b1;
        load_valid = 1'b1;
        load_data  = 8'h55;
        tick();
        load_start = 1'b0;
        load_valid = 1'b0;
        check("drop_count", 80'(load_count), 80'd0);
        check("drop_ready", 80'(load_ready), 80'd1);
        check("drop_mem",   80'(rdata[7:0]), 80'h A0);

        // Overflow: MEM_SIZE bytes without last
        for (int i = 0; i < MS - 1; i++) send_byte(ovf_byte(i), 1'b0);
        check("ovf_count_pre", 80'(load_count), 80'(MS - 1));
        check("ovf_ready_pre", 80'(load_ready), 80'd1);
        send_byte(ovf_byte(MS - 1), 1'b0);
        check("ovf_err",   80'(load_err), 80'd1);
        check("ovf_ready", 80'(load_ready), 80'd0);
        check("ovf_count", 80'(load_count), 80'(MS));
        check("ovf_stall", 80'(cpu_stall), 80'd1);
        check("ovf_done",  80'(load_done), 80'd0);
        check("ovf_state", 80'(load_state), 80'(LS_ERR));
        // Boundary reads
        f_pc = 64'(MS - 4);
        #1;
        exp_word = {ovf_byte(MS - 1), ovf_byte(MS - 2), ovf_byte(MS - 3), ovf_byte(MS - 4)};
        check("edge_low",  80'(rdata[31:0]), 80'(exp_word));
        check("edge_high", 80'(rdata[79:32]), 80'd0);
        check("edge_ierr", 80'(imem_error), 80'd0);
        f_pc = 64'(MS);
        #1;
        check("end_ierr",  80'(imem_error), 80'd1);
        check("end_rdata", rdata, 80'd0);
        f_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        #1;
        check("huge_rdata", rdata, 80'd0);
        check("huge_ierr",  80'(imem_error), 80'd1);

        // Recover from ERR with a 1-byte program
        f_pc = 64'd0;
        start_load();
        check("rec_ready", 80'(load_ready), 80'd1);
        send_byte(8'h77, 1'b1);
        check("rec_err",   80'(load_err), 80'd0);
        check("rec_done",  80'(load_done), 80'd1);
        check("rec_count", 80'(load_count), 80'd1);
        fill_byte = ovf_byte(1);
        check("rec_mem", 80'(rdata[15:0]), 80'({fill_byte, 8'h77}));

        // Same-cycle write/read of address 0, then reset after 5 bytes
        start_load();
        load_valid = 1'b1;
        load_data  = 8'hC0;
        #1;
        check("wr_old", 80'(rdata[7:0]), 80'h77);
        tick();
        load_valid = 1'b0;
        check("wr_new", 80'(rdata[7:0]), 80'h C0);
        for (int i = 1; i < 5; i++) send_byte(8'hC0 + 8'(i), 1'b0);
        check("mid_count", 80'(load_count), 80'd5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_state", 80'(load_state), 80'(LS_IDLE));
        check("mid_stall", 80'(cpu_stall), 80'd1);
        check("mid_done",  80'(load_done), 80'd0);
        check("mid_ready", 80'(load_ready), 80'd0);
        check("mid_count0", 80'(load_count), 80'd0);
        check("mid_mem",   80'(rdata[39:0]), 80'h C4_C3C2_C1C0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
